// File: rtl/rst_interrupt_controller.sv
// Priority interrupt controller supplying RST opcodes to an 8080-style core.
// Mask/EOI/status registers live on the CPU port bus at PORT_BASE..PORT_BASE+2.
module rst_interrupt_controller #(
  parameter int unsigned CHANNELS  = 8,
  parameter logic [7:0]  PORT_BASE = 8'h00,
  parameter bit          EDGE      = 1'b1,
  parameter int unsigned RST_BASE  = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic [CHANNELS-1:0] irq_in,
  input  logic [7:0]          port,
  input  logic                port_we,
  input  logic [7:0]          port_wdata,
  output logic [7:0]          port_rdata,
  output logic                irq,
  input  logic                inta,
  output logic [7:0]          vector
);

  localparam logic [7:0] P_IMR   = PORT_BASE;
  localparam logic [7:0] P_CMD   = PORT_BASE + 8'd1;
  localparam logic [7:0] P_IRR   = PORT_BASE + 8'd2;
  localparam logic [2:0] RST_OFS = 3'(RST_BASE % 8);

  logic [CHANNELS-1:0] r_imr, r_isr, r_irr, r_hist;
  logic                r_irq;
  logic [7:0]          r_vector;

  logic [CHANNELS-1:0] w_pending, w_win_onehot, w_isr_low;
  logic [CHANNELS-1:0] w_eoi_mask, w_isr_set, w_isr_next, w_irr_next;
  logic [2:0]          w_win_idx, w_isr_idx;
  logic                w_win_valid, w_isr_any, w_eligible;
  logic                w_wr_imr, w_wr_cmd;
  logic [7:0]          w_vec_next;

  // Lowest-index search for both the pending winner and the highest in-service level
  always_comb begin
    w_pending    = r_irr & ~r_imr;
    w_win_valid  = 1'b0;
    w_win_idx    = '0;
    w_win_onehot = '0;
    w_isr_any    = 1'b0;
    w_isr_idx    = '0;
    w_isr_low    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (w_pending[i] && !w_win_valid) begin
        w_win_valid     = 1'b1;
        w_win_idx       = 3'(i);
        w_win_onehot[i] = 1'b1;
      end
      if (r_isr[i] && !w_isr_any) begin
        w_isr_any    = 1'b1;
        w_isr_idx    = 3'(i);
        w_isr_low[i] = 1'b1;
      end
    end
    w_eligible = w_win_valid && (!w_isr_any || (w_win_idx < w_isr_idx));
  end

  always_comb begin
    w_wr_imr   = port_we && (port == P_IMR);
    w_wr_cmd   = port_we && (port == P_CMD);
    w_eoi_mask = '0;
    if (w_wr_cmd && port_wdata[7]) w_eoi_mask = w_isr_low;
    if (w_wr_cmd && port_wdata[6]) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (port_wdata[2:0] == 3'(i)) w_eoi_mask[i] = 1'b1;
      end
    end
    w_isr_set  = (inta && w_eligible) ? w_win_onehot : '0;
    // EOI clears before the acknowledge sets, so a same-bit collision leaves it set
    w_isr_next = (r_isr & ~w_eoi_mask) | w_isr_set;
    if (EDGE) begin
      w_irr_next = (w_wr_cmd && port_wdata[0]) ? '0 : (r_irr & ~w_isr_set);
      w_irr_next = w_irr_next | (irq_in & ~r_hist);
    end else begin
      w_irr_next = irq_in;
    end
    w_vec_next = r_vector;
    if (inta) w_vec_next = w_eligible ? {2'b11, w_win_idx + RST_OFS, 3'b111} : 8'hFF;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_imr    <= '1;
      r_isr    <= '0;
      r_irr    <= '0;
      r_hist   <= irq_in;
      r_irq    <= 1'b0;
      r_vector <= 8'hFF;
    end else if (ce) begin
      if (w_wr_imr) r_imr <= port_wdata[CHANNELS-1:0];
      r_isr    <= w_isr_next;
      r_irr    <= w_irr_next;
      r_hist   <= irq_in;
      r_irq    <= w_eligible;
      r_vector <= w_vec_next;
    end
  end

  always_comb begin
    port_rdata = '0;
    case (port)
      P_IMR:   port_rdata[CHANNELS-1:0] = r_imr;
      P_CMD:   port_rdata[CHANNELS-1:0] = r_isr;
      P_IRR:   port_rdata[CHANNELS-1:0] = r_irr;
      default: port_rdata = '0;
    endcase
  end

  assign irq    = r_irq;
  assign vector = r_vector;

endmodule

// File: tb/tb_rst_interrupt_controller.sv
// Bench for rst_interrupt_controller: two configurations checked every cycle
// against a register-level behavioural model, plus directed literal checks.
module tb_rst_interrupt_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b1;
  logic [7:0] irq_a = 8'h00;
  logic [5:0] irq_b = 6'h00;
  logic [7:0] port = 8'h00;
  logic       port_we = 1'b0;
  logic [7:0] port_wdata = 8'h00;
  logic       inta = 1'b0;
  logic [7:0] rdata_a, rdata_b, vec_a, vec_b;
  logic       irqo_a, irqo_b;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  always #5 clock = ~clock;

  rst_interrupt_controller #(.CHANNELS(8), .PORT_BASE(8'h00), .EDGE(1'b1), .RST_BASE(0)) dut_a (
    .clock(clock), .reset(reset), .ce(ce), .irq_in(irq_a), .port(port), .port_we(port_we),
    .port_wdata(port_wdata), .port_rdata(rdata_a), .irq(irqo_a), .inta(inta), .vector(vec_a));

  rst_interrupt_controller #(.CHANNELS(6), .PORT_BASE(8'h40), .EDGE(1'b0), .RST_BASE(6)) dut_b (
    .clock(clock), .reset(reset), .ce(ce), .irq_in(irq_b), .port(port), .port_we(port_we),
    .port_wdata(port_wdata), .port_rdata(rdata_b), .irq(irqo_b), .inta(inta), .vector(vec_b));

  typedef struct {
    logic [7:0] imr, isr, irr, hist, vector;
    logic       irq;
  } mstate_t;

  mstate_t ma, mb;

  function automatic int lowest(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  function automatic mstate_t mstep(mstate_t s, int ch, bit edge_mode, int rbase, logic [7:0] pbase,
                                    logic [7:0] irqin);
    mstate_t    n;
    logic [7:0] mask;
    int         win, top, idx;
    bit         elig, cmd;
    mask = 8'((1 << ch) - 1);
    n = s;
    if (reset) begin
      n.imr = mask; n.isr = 8'h00; n.irr = 8'h00; n.hist = irqin & mask;
      n.irq = 1'b0; n.vector = 8'hFF;
      return n;
    end
    if (!ce) return n;
    win  = lowest(s.irr & ~s.imr & mask);
    top  = lowest(s.isr & mask);
    elig = (win < 8) && (win < top);
    cmd  = port_we && (port == pbase + 8'd1);
    n.irq = elig;
    if (cmd && port_wdata[7] && top < 8) n.isr[top] = 1'b0;
    idx = int'(port_wdata[2:0]);
    if (cmd && port_wdata[6] && idx < ch) n.isr[idx] = 1'b0;
    if (inta) begin
      if (elig) begin
        n.isr[win] = 1'b1;
        n.vector = 8'hC7 | 8'(((rbase + win) % 8) << 3);
      end else begin
        n.vector = 8'hFF;
      end
    end
    if (edge_mode) begin
      if (inta && elig) n.irr[win] = 1'b0;
      if (cmd && port_wdata[0]) n.irr = 8'h00;
      n.irr = n.irr | (irqin & ~s.hist & mask);
    end else begin
      n.irr = irqin & mask;
    end
    n.hist = irqin & mask;
    if (port_we && port == pbase) n.imr = port_wdata & mask;
    return n;
  endfunction

  function automatic logic [7:0] mread(mstate_t s, logic [7:0] pbase);
    if (port == pbase) return s.imr;
    if (port == pbase + 8'd1) return s.isr;
    if (port == pbase + 8'd2) return s.irr;
    return 8'h00;
  endfunction

  always @(posedge clock) begin
    ma = mstep(ma, 8, 1'b1, 0, 8'h00, irq_a);
    mb = mstep(mb, 6, 1'b0, 6, 8'h40, {2'b00, irq_b});
    if (reset) started = 1'b1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      chk("a_irq", {7'b0, irqo_a}, {7'b0, ma.irq});
      chk("a_vector", vec_a, ma.vector);
      chk("a_rdata", rdata_a, mread(ma, 8'h00));
      chk("b_irq", {7'b0, irqo_b}, {7'b0, mb.irq});
      chk("b_vector", vec_b, mb.vector);
      chk("b_rdata", rdata_b, mread(mb, 8'h40));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port = a; port_we = 1'b1; port_wdata = d;
    step();
    port_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] da, output logic [7:0] db);
    port = a;
    #1;
    da = rdata_a;
    db = rdata_b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] ra, rb;

    // Line 0 already high through reset: no edge may be recorded
    irq_a = 8'h01;
    do_reset();
    chk("rst_vector", vec_a, 8'hFF);
    chk("rst_irq", {7'b0, irqo_a}, 8'h00);
    rd(8'h00, ra, rb); chk("rst_imr", ra, 8'hFF);
    wr(8'h00, 8'h00);
    step(); step();
    chk("t1_no_edge_irq", {7'b0, irqo_a}, 8'h00);
    irq_a = 8'h00; step();
    irq_a = 8'h01; step();
    step();
    chk("t1_reraise_irq", {7'b0, irqo_a}, 8'h01);

    irq_a = 8'h00;
    do_reset();
    wr(8'h00, 8'h00);
    irq_a = 8'h08; step(); step();
    chk("t2_irq", {7'b0, irqo_a}, 8'h01);
    inta = 1'b1; step(); inta = 1'b0;
    chk("t2_vec", vec_a, 8'hDF);
    chk("t2_vec_model", ma.vector, 8'hDF);
    rd(8'h01, ra, rb); chk("t2_isr", ra, 8'h08);
    rd(8'h02, ra, rb); chk("t2_irr", ra, 8'h00);
    step();
    chk("t2_irq_fall", {7'b0, irqo_a}, 8'h00);

    irq_a = 8'h28; step(); step();
    chk("t3_nest_block", {7'b0, irqo_a}, 8'h00);
    irq_a = 8'h2A; step(); step();
    chk("t3_higher_irq", {7'b0, irqo_a}, 8'h01);
    inta = 1'b1; step(); inta = 1'b0;
    chk("t3_vec", vec_a, 8'hCF);
    rd(8'h01, ra, rb); chk("t3_isr", ra, 8'h0A);
    chk("t3_isr_model", ma.isr, 8'h0A);
    wr(8'h01, 8'h80);
    rd(8'h01, ra, rb); chk("t3_eoi1_isr", ra, 8'h08);
    step();
    chk("t3_ch5_blocked", {7'b0, irqo_a}, 8'h00);
    wr(8'h01, 8'h80);
    step();
    chk("t3_ch5_released", {7'b0, irqo_a}, 8'h01);

    irq_a = 8'h00;
    do_reset();
    irq_a = 8'h04; step(); step();
    rd(8'h02, ra, rb); chk("t4_irr_masked", ra, 8'h04);
    chk("t4_irq_masked", {7'b0, irqo_a}, 8'h00);
    wr(8'h00, 8'h00);
    step();
    chk("t4_irq_unmasked", {7'b0, irqo_a}, 8'h01);

    inta = 1'b1; step(); inta = 1'b0;
    chk("t5_vec_rst2", vec_a, 8'hD7);
    inta = 1'b1; step(); inta = 1'b0;
    chk("t5_spurious_vec", vec_a, 8'hFF);
    rd(8'h01, ra, rb); chk("t5_isr_kept", ra, 8'h04);

    irq_a = 8'h05; step(); step();
    inta = 1'b1; port = 8'h01; port_we = 1'b1; port_wdata = 8'h40;
    step();
    inta = 1'b0; port_we = 1'b0;
    chk("t6_vec", vec_a, 8'hC7);
    rd(8'h01, ra, rb); chk("t6_isr_set_wins", ra, 8'h05);

    irq_a = 8'h00;
    do_reset();
    wr(8'h00, 8'h00);
    ce = 1'b0; irq_a = 8'h10;
    port = 8'h00; port_we = 1'b1; port_wdata = 8'hFF;
    repeat (5) step();
    port_we = 1'b0;
    chk("t7_ce_irq", {7'b0, irqo_a}, 8'h00);
    rd(8'h02, ra, rb); chk("t7_ce_irr", ra, 8'h00);
    rd(8'h00, ra, rb); chk("t7_ce_imr", ra, 8'h00);
    ce = 1'b1; step(); step();
    chk("t7_resume_irq", {7'b0, irqo_a}, 8'h01);
    ce = 1'b0; reset = 1'b1; step(); reset = 1'b0; ce = 1'b1;
    chk("t7_rst_noce_irq", {7'b0, irqo_a}, 8'h00);
    rd(8'h00, ra, rb); chk("t7_rst_noce_imr", ra, 8'hFF);

    irq_a = 8'h00;
    do_reset();
    wr(8'h40, 8'h00);
    irq_b = 6'h08; step(); step();
    chk("t8_b_irq", {7'b0, irqo_b}, 8'h01);
    inta = 1'b1; step(); inta = 1'b0;
    chk("t8_b_vec_wrap", vec_b, 8'hCF);
    chk("t8_b_vec_model", mb.vector, 8'hCF);
    rd(8'h41, ra, rb); chk("t8_b_isr", rb, 8'h08);
    wr(8'h41, 8'h46);
    rd(8'h41, ra, rb); chk("t8_b_eoi_oob", rb, 8'h08);
    wr(8'h40, 8'hFF);
    rd(8'h40, ra, rb); chk("t8_b_imr_width", rb, 8'h3F);
    wr(8'h41, 8'h80);
    rd(8'h41, ra, rb); chk("t8_b_eoi", rb, 8'h00);

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] addrs [8];
      addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h40, 8'h41, 8'h42, 8'h43};
      reset      = ($urandom_range(0, 199) == 0);
      ce         = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 3) == 0) irq_a = 8'($urandom());
      if ($urandom_range(0, 3) == 0) irq_b = 6'($urandom());
      port       = addrs[$urandom_range(0, 7)];
      port_we    = ($urandom_range(0, 4) == 0);
      port_wdata = 8'($urandom());
      inta       = ($urandom_range(0, 6) == 0);
      step();
    end
    reset = 1'b0; port_we = 1'b0; inta = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
